// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word memory answering MEM-stage LW/SW
// requests over valid/ready, with a programmable wait-state counter and one
// transaction outstanding at a time.
module mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                err_d;
  logic                ready_d;
  logic                valid_d;
  logic                busy_d;
  logic                mem_we_c;
  logic                in_range_c;
  logic [DATA_W-1:0]   mem_rd_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Range check and combinational read of the captured address; addresses
  // at or above DEPTH never alias onto implemented words.
  always_comb begin
    in_range_c = (32'(addr_q) < DEPTH);
    mem_rd_c   = mem[addr_q[IDX_W-1:0]];
  end

  // Next-state, capture, wait countdown and access decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rsp_rdata;
    err_d    = rsp_err;
    mem_we_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_RESP;
          if (!in_range_c) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (we_q) begin
            mem_we_c = 1'b1;
            rdata_d  = wdata_q;
            err_d    = 1'b0;
          end else begin
            rdata_d = mem_rd_c;
            err_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, capture and registered outputs; reset clears everything but memory.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
      busy      <= busy_d;
    end
  end

  // Storage array; a store commits on the edge that leaves WAIT.
  always_ff @(posedge clk1) begin
    if (mem_we_c) begin
      mem[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder over three
// configurations (DEPTH 512/LAT 2, DEPTH 1024/LAT 0, DEPTH 1024/LAT 5).
module tb_mem_responder;

  localparam int NDUT = 3;

  logic        clk1 = 1'b0;
  logic        rst_n     [NDUT];
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [9:0]  req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];
  logic        busy      [NDUT];

  int dep [NDUT] = '{512, 1024, 1024};
  int lat [NDUT] = '{2, 0, 5};

  logic [31:0] mdl [NDUT][1024];
  logic [32:0] sb_q [$];

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clk1 = ~clk1;

  // Rising-edge counter used for latency and spacing checks.
  always @(posedge clk1) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(10), .DEPTH(512), .LATENCY(2)) u_dut0 (
    .clk1(clk1), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  mem_responder #(.ADDR_W(10), .DEPTH(1024), .LATENCY(0)) u_dut1 (
    .clk1(clk1), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  mem_responder #(.ADDR_W(10), .DEPTH(1024), .LATENCY(5)) u_dut2 (
    .clk1(clk1), .rst_n(rst_n[2]),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reset-value checks for one instance.
  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_busy"},      32'(busy[d]),      32'd0);
    chk({tag, "_rdata"},     rsp_rdata[d],      32'd0);
    chk({tag, "_err"},       32'(rsp_err[d]),   32'd0);
  endtask

  // One transaction: expected response from the model is queued when the
  // request is driven, and popped when the response appears. hold > 0 keeps
  // rsp_ready low that many cycles while a competing request is presented.
  task automatic do_txn(input int d, input logic we, input logic [9:0] addr,
                        input logic [31:0] wdata, input int hold, input string tag);
    logic [32:0] exp_v;
    logic [31:0] held;
    int          acc;
    int          k;

    if (int'(addr) >= dep[d]) begin
      exp_v = {1'b1, 32'h0};
    end else if (we) begin
      exp_v = {1'b0, wdata};
      mdl[d][addr] = wdata;
    end else begin
      exp_v = {1'b0, mdl[d][addr]};
    end
    sb_q.push_back(exp_v);

    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    rsp_ready[d] = (hold == 0);

    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk1);
      k++;
    end
    if (!req_ready[d]) begin
      chk({tag, "_accept_timeout"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    acc = cyc + 1;
    last_acc = acc;

    @(negedge clk1);
    req_valid[d] = 1'b0;
    chk({tag, "_busy"}, 32'(busy[d]), 32'd1);

    k = 0;
    while (!rsp_valid[d] && k < 50) begin
      @(negedge clk1);
      k++;
    end
    if (!rsp_valid[d]) begin
      chk({tag, "_rsp_timeout"}, 32'(rsp_valid[d]), 32'd1);
      void'(sb_q.pop_front());
      return;
    end
    chk({tag, "_lat"}, 32'(cyc - acc), 32'(lat[d] + 1));
    exp_v = sb_q.pop_front();
    chk({tag, "_data"}, rsp_rdata[d], exp_v[31:0]);
    chk({tag, "_err"},  32'(rsp_err[d]), 32'(exp_v[32]));

    if (hold > 0) begin
      held = rsp_rdata[d];
      req_we[d]    = 1'b1;
      req_addr[d]  = addr;
      req_wdata[d] = ~held;
      req_valid[d] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk1);
        chk({tag, "_bp_valid"}, 32'(rsp_valid[d]), 32'd1);
        chk({tag, "_bp_data"},  rsp_rdata[d],      held);
        chk({tag, "_bp_ready"}, 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
    end

    @(negedge clk1);
    req_valid[d] = 1'b0;
    chk({tag, "_done_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_done_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    int prev;
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
    end

    // Reset and release.
    repeat (3) @(negedge clk1);
    chk_reset(0, "rst_in");
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
    @(negedge clk1);
    for (int d = 0; d < NDUT; d++) chk_reset(d, "rst_out");

    // Store, store-then-load, second address.
    do_txn(0, 1'b1, 10'd5, 32'hDEADBEEF, 0, "st5a");
    do_txn(0, 1'b1, 10'd5, 32'h12345678, 0, "st5b");
    do_txn(0, 1'b0, 10'd5, 32'h0,        0, "ld5");
    do_txn(0, 1'b1, 10'd6, 32'h00000001, 0, "st6");
    do_txn(0, 1'b0, 10'd6, 32'h0,        0, "ld6");

    // Response backpressure with a competing store that must be ignored.
    do_txn(0, 1'b0, 10'd5, 32'h0, 4, "bp5");
    do_txn(0, 1'b0, 10'd5, 32'h0, 0, "bp5_after");

    // Out-of-range handling and the DEPTH boundary.
    do_txn(0, 1'b1, 10'd88,  32'h0BADF00D, 0, "st88");
    do_txn(0, 1'b1, 10'd600, 32'hFFFFFFFF, 0, "st600");
    do_txn(0, 1'b0, 10'd88,  32'h0,        0, "ld88");
    do_txn(0, 1'b0, 10'd600, 32'h0,        0, "ld600");
    do_txn(0, 1'b1, 10'd511, 32'hCAFE0511, 0, "st511");
    do_txn(0, 1'b0, 10'd511, 32'h0,        0, "ld511");
    do_txn(0, 1'b0, 10'd512, 32'h0,        0, "ld512");

    // LATENCY=0: back-to-back traffic, accepts spaced three cycles apart.
    for (int i = 0; i < 4; i++)
      do_txn(1, 1'b1, 10'(100 + i), 32'hA5000000 + 32'(i * 17), 0, "z_st");
    do_txn(1, 1'b0, 10'd100, 32'h0, 0, "z_ld");
    prev = last_acc;
    for (int i = 1; i < 4; i++) begin
      do_txn(1, 1'b0, 10'(100 + i), 32'h0, 0, "z_ld");
      chk("z_gap", 32'(last_acc - prev), 32'd3);
      prev = last_acc;
    end

    // Reset while a store sits in WAIT: outputs clear at once, store is lost.
    do_txn(2, 1'b1, 10'd9, 32'h00000000, 0, "r_pre9");
    do_txn(2, 1'b1, 10'd3, 32'h13579BDF, 0, "r_pre3");
    req_we[2]    = 1'b1;
    req_addr[2]  = 10'd9;
    req_wdata[2] = 32'hAAAA5555;
    req_valid[2] = 1'b1;
    @(negedge clk1);
    req_valid[2] = 1'b0;
    @(negedge clk1);
    chk("r_wait_busy",  32'(busy[2]), 32'd1);
    chk("r_wait_rdata", rsp_rdata[2], 32'h13579BDF);
    #1 rst_n[2] = 1'b0;
    #1 chk_reset(2, "r_async");
    repeat (2) @(negedge clk1);
    rst_n[2] = 1'b1;
    @(negedge clk1);
    do_txn(2, 1'b0, 10'd9, 32'h0, 0, "r_ld9");
    do_txn(2, 1'b0, 10'd3, 32'h0, 0, "r_ld3");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

endmodule
